// File: rtl/mole_pkg.sv
// mole_pkg: shared types, LFSR constants and small arithmetic helpers
// for the multi-mole whack-a-mole game core.
package mole_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PLAY,
        OVER
    } state_t;

    localparam int          LFSR_W        = 16;
    // Right-shifting Fibonacci form of taps 16,14,13,11
    localparam logic [15:0] LFSR_TAPS     = 16'h002D;
    localparam logic [15:0] LFSR_SEED_DEF = 16'hACE1;

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {^(s & LFSR_TAPS), s[15:1]};
    endfunction

    function automatic logic [4:0] popcount(input logic [15:0] v);
        logic [4:0] c;
        c = '0;
        for (int i = 0; i < 16; i++) begin
            c = c + {4'd0, v[i]};
        end
        return c;
    endfunction

    function automatic logic [15:0] sat_addsub(
        input logic [15:0] val,
        input logic [4:0]  add,
        input logic [4:0]  sub,
        input logic [15:0] max_v
    );
        logic [17:0] sum;
        sum = {2'b00, val} + {13'd0, add};
        if (sum < {13'd0, sub}) begin
            return '0;
        end
        sum = sum - {13'd0, sub};
        if (sum > {2'b00, max_v}) begin
            return max_v;
        end
        return sum[15:0];
    endfunction

endpackage

// File: rtl/mole_field_ctrl_slot.sv
// mole_slot: one mole position holding its lit flag and remaining lifetime.
// A hit on the expiring tick clears the mole without reporting an expiry.
module mole_slot #(
    parameter int LIFE_W = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              clear,
    input  logic              spawn_en,
    input  logic [LIFE_W-1:0] life_load,
    input  logic              tick,
    input  logic              hit,
    output logic              active,
    output logic              expire
);

    logic [LIFE_W-1:0] life;

    assign expire = active && tick && !hit && (life == LIFE_W'(1));

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            active <= 1'b0;
            life   <= '0;
        end else if (spawn_en) begin
            active <= 1'b1;
            life   <= life_load;
        end else if (hit || expire) begin
            active <= 1'b0;
            life   <= '0;
        end else if (active && tick) begin
            life <= life - 1'b1;
        end
    end

endmodule

// File: rtl/mole_field_ctrl.sv
// mole_field_ctrl: whack-a-mole game core (round timer, spawner, score, levels).
// Define MOLE_WHIFF_PENALTY_EN to charge one point per press on an unlit slot.
module mole_field_ctrl
    import mole_pkg::*;
#(
    parameter int          N_MOLES     = 5,
    parameter int          MAX_ACTIVE  = 2,
    parameter int          GAME_TICKS  = 60,
    parameter int          SPAWN_TICKS = 1,
    parameter int          LIFE_INIT   = 3,
    parameter int          LIFE_MIN    = 1,
    parameter int          LEVEL_HITS  = 8,
    parameter int          SCORE_W     = 8,
    parameter logic [15:0] LFSR_SEED   = LFSR_SEED_DEF
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic                              tick,
    input  logic                              start,
    input  logic [N_MOLES-1:0]                hit_btn,
    output logic [N_MOLES-1:0]                mole_led,
    output logic [SCORE_W-1:0]                score,
    output logic [7:0]                        misses,
    output logic [3:0]                        level,
    output logic [$clog2(GAME_TICKS+1)-1:0]   time_left,
    output logic                              game_active,
    output logic                              game_over
);

    localparam int          TL_W      = $clog2(GAME_TICKS + 1);
    localparam int          SP_W      = (SPAWN_TICKS < 2) ? 1 : $clog2(SPAWN_TICKS);
    localparam int          LIFE_W    = (LIFE_INIT < 2) ? 1 : $clog2(LIFE_INIT + 1);
    localparam int          IDX_W     = $clog2(N_MOLES);
    localparam int          ACC_W     = $clog2(LEVEL_HITS + 17);
    localparam logic [15:0] SCORE_MAX = 16'((1 << SCORE_W) - 1);

    state_t              state;
    logic [LFSR_W-1:0]   lfsr;
    logic [SP_W-1:0]     spawn_cnt;
    logic [ACC_W-1:0]    hit_acc;

    logic                in_play;
    logic                play_tick;
    logic                last_tick;
    logic                clear_slots;
    logic [N_MOLES-1:0]  hits;
    logic [N_MOLES-1:0]  expire;
    logic [N_MOLES-1:0]  spawn_vec;
    logic [4:0]          n_hit;
    logic [4:0]          n_whiff;
    logic [4:0]          n_exp;
    logic [SCORE_W-1:0]  score_nxt;
    logic [7:0]          misses_nxt;
    logic [3:0]          level_nxt;
    logic [ACC_W-1:0]    acc_nxt;
    logic [LIFE_W-1:0]   life_cur;
    logic                spawn_try;
    logic                found;
    logic [IDX_W-1:0]    slot_idx;
    int                  acc_sum;
    int                  life_i;
    int                  cand;
    int                  slot;

    assign in_play     = (state == PLAY);
    assign play_tick   = in_play && tick;
    assign last_tick   = play_tick && (time_left == TL_W'(1));
    assign clear_slots = (start && !in_play) || last_tick;
    assign hits        = hit_btn & mole_led & {N_MOLES{in_play}};

    always_comb begin
        n_hit   = popcount(16'(hits));
        n_whiff = '0;
`ifdef MOLE_WHIFF_PENALTY_EN
        n_whiff = popcount(16'(hit_btn & ~mole_led & {N_MOLES{in_play}}));
`endif
        n_exp      = popcount(16'(expire));
        score_nxt  = SCORE_W'(sat_addsub(16'(score), n_hit, n_whiff, SCORE_MAX));
        misses_nxt = 8'(sat_addsub(16'(misses), n_exp, 5'd0, 16'd255));
        acc_sum    = int'(hit_acc) + int'(n_hit);
        level_nxt  = 4'(sat_addsub(16'(level), 5'(acc_sum / LEVEL_HITS),
                                   5'd0, 16'd15));
        acc_nxt    = ACC_W'(acc_sum % LEVEL_HITS);
    end

    // Spawn sees only registered occupancy, so slots freed this cycle stay taken
    always_comb begin
        life_i = LIFE_INIT - int'(level);
        if (life_i < LIFE_MIN) begin
            life_i = LIFE_MIN;
        end
        life_cur  = LIFE_W'(life_i);
        spawn_try = play_tick
                 && (spawn_cnt == SP_W'(SPAWN_TICKS - 1))
                 && (popcount(16'(mole_led)) < 5'(MAX_ACTIVE));
        cand      = int'(lfsr[7:0]) % N_MOLES;
        spawn_vec = '0;
        found     = 1'b0;
        slot      = 0;
        slot_idx  = '0;
        for (int k = 0; k < N_MOLES; k++) begin
            slot = cand + k;
            if (slot >= N_MOLES) begin
                slot = slot - N_MOLES;
            end
            slot_idx = IDX_W'(slot);
            if (spawn_try && !found && !mole_led[slot_idx]) begin
                spawn_vec[slot_idx] = 1'b1;
                found               = 1'b1;
            end
        end
    end

    for (genvar i = 0; i < N_MOLES; i++) begin : g_slot
        mole_slot #(
            .LIFE_W(LIFE_W)
        ) u_slot (
            .clock    (clock),
            .reset    (reset),
            .clear    (clear_slots),
            .spawn_en (spawn_vec[i]),
            .life_load(life_cur),
            .tick     (play_tick),
            .hit      (hits[i]),
            .active   (mole_led[i]),
            .expire   (expire[i])
        );
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            lfsr        <= LFSR_SEED;
            score       <= '0;
            misses      <= '0;
            level       <= '0;
            time_left   <= TL_W'(GAME_TICKS);
            game_active <= 1'b0;
            game_over   <= 1'b0;
            spawn_cnt   <= '0;
            hit_acc     <= '0;
        end else begin
            lfsr <= lfsr_next(lfsr);
            unique case (state)
                IDLE, OVER: begin
                    if (start) begin
                        state       <= PLAY;
                        game_active <= 1'b1;
                        game_over   <= 1'b0;
                        score       <= '0;
                        misses      <= '0;
                        level       <= '0;
                        time_left   <= TL_W'(GAME_TICKS);
                        spawn_cnt   <= '0;
                        hit_acc     <= '0;
                    end
                end
                PLAY: begin
                    score   <= score_nxt;
                    misses  <= misses_nxt;
                    level   <= level_nxt;
                    hit_acc <= acc_nxt;
                    if (tick) begin
                        spawn_cnt <= (spawn_cnt == SP_W'(SPAWN_TICKS - 1))
                                   ? '0 : spawn_cnt + 1'b1;
                        time_left <= time_left - 1'b1;
                        if (last_tick) begin
                            state       <= OVER;
                            game_active <= 1'b0;
                            game_over   <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/mole_field_ctrl.md
Name: mole_field_ctrl

Overview:
- Parametrised game core for the whack-a-mole design. Handles N_MOLES independent moles, each with its own lifetime, and up to MAX_ACTIVE moles lit at once.
- Contains the round timer, saturating score, miss counter and difficulty levels that shorten mole lifetime as the player scores.
- Sits between the button debouncers / clock dividers and the LED and display drivers. Replaces the separate FSM and single-mole generator pairing.

Parameters:
- N_MOLES, 5, number of mole slots (2..16).
- MAX_ACTIVE, 2, maximum simultaneously lit moles (1..N_MOLES).
- GAME_TICKS, 60, round length in ticks.
- SPAWN_TICKS, 1, ticks between spawn attempts.
- LIFE_INIT, 3, mole lifetime in ticks at level 0.
- LIFE_MIN, 1, lifetime floor.
- LEVEL_HITS, 8, hits per level-up.
- SCORE_W, 8, score width; saturates at 2^SCORE_W-1.
- LFSR_SEED, 16'hACE1, non-zero LFSR reset seed.

Ports:
- clock  in  1  system clock, 100 MHz.
- reset  in  1  synchronous, active-high.
- tick  in  1  one-cycle enable pulse from the clock divider.
- start  in  1  one-cycle debounced start pulse.
- hit_btn  in  N_MOLES  one-cycle debounced button pulses.
- mole_led  out  N_MOLES  lit-mole mask.
- score  out  SCORE_W  hits this round.
- misses  out  8  expired moles this round; saturating.
- level  out  4  current difficulty level; saturating at 15.
- time_left  out  clog2(GAME_TICKS+1)  remaining ticks.
- game_active  out  1  high in PLAY.
- game_over  out  1  high in OVER.

Behaviour:
- Reset values:
  - State IDLE; mole_led, score, misses and level are 0.
  - time_left = GAME_TICKS; game_active = game_over = 0; LFSR = LFSR_SEED.
  - Reset dominates all other inputs on the same edge.
- FSM states and transitions:
  - IDLE: start -> PLAY.
  - PLAY: the tick on which time_left is 1 decrements it to 0; state is OVER on the next edge.
  - OVER: start -> PLAY. There is no path back to IDLE except reset.
- Entering PLAY (from IDLE or OVER):
  - Clears score, misses, level and mole_led.
  - Loads time_left = GAME_TICKS and sets current lifetime = LIFE_INIT.
- Entering OVER: mole_led is cleared the same edge; score, misses and level hold until the next start.
- In PLAY, start is ignored (no restart mid-round).
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. It advances every clock in all states so the start time randomises the sequence.
- Spawn (PLAY only):
  - A spawn attempt occurs every SPAWN_TICKS-th tick.
  - It is made only if popcount(registered mole_led) < MAX_ACTIVE.
  - Candidate = LFSR[7:0] mod N_MOLES. If the candidate is occupied, take the first free slot scanning upward from the candidate, wrapping around.
  - The new mole lights on the edge after the tick, with its lifetime counter loaded from the current lifetime.
- Lifetime: each lit mole decrements its counter on every tick. When a counter at 1 is ticked, the mole clears and misses increments, saturating at 255.
- Hit: hit_btn[i] with mole_led[i]=1 clears mole i on the next edge and adds 1 to score, saturating.
- Simultaneous events:
  - Multiple hits in one cycle: score += popcount of the hits, saturating.
  - Hit and expiry on the same mole in one cycle: the hit wins and misses is unchanged.
  - Spawn in the same cycle as a hit: spawn uses the pre-clear occupancy, so the hit slot cannot be re-spawned that cycle.
  - Hit on the final tick: the hit counts, then the FSM enters OVER.
- Level-up:
  - Each time the cumulative hit count crosses a multiple of LEVEL_HITS, level increments.
  - Lifetime becomes max(LIFE_MIN, LIFE_INIT - level).
  - The new lifetime applies to moles spawned afterwards; lit moles keep their counters.
- hit_btn and tick are ignored outside PLAY.
- Registered outputs: one-cycle latency from the causing input.

Optional Feature:
- Macro MOLE_WHIFF_PENALTY_EN.
- Defined: a hit_btn[i] pulse on an unlit slot in PLAY decrements score by 1, floor 0. It is netted against same-cycle hits, e.g. 2 hits + 1 whiff = +1.
- Undefined: presses on unlit slots are ignored.

Decomposition:
- Package mole_pkg holds:
  - The state enum (IDLE, PLAY, OVER).
  - The LFSR width, taps and default seed constants.
  - A popcount function and a saturating add/sub function.
- Sub-module mole_slot, instantiated N_MOLES times with a generate loop.
  - Holds the active flag and lifetime counter for one mole.
  - Inputs: spawn_en, life_load, tick, hit. Outputs: active, expire.

Test Plan:
- Reset, then start, with tick asserted every cycle, GAME_TICKS=10, N_MOLES=5, MAX_ACTIVE=2 -> game_active next cycle; time_left counts 10..0; game_over=1 after 10 ticks; mole_led=0 in OVER.
- Every lit mole pressed the cycle it appears, LEVEL_HITS=4, LIFE_INIT=3 -> score=4 and level=1 after 4 hits; new moles live 2 ticks; lifetime floors at LIFE_MIN=1 at level 2+.
- No presses, LIFE_INIT=3 -> each mole clears exactly 3 ticks after it lights; misses increments per expiry; popcount(mole_led) never exceeds 2.
- Hit on mole 2 in the same cycle as its lifetime expiry -> score+1, misses unchanged; hits on moles 1 and 3 in the same cycle -> score+2.
- SCORE_W=3, 9 hits -> score saturates at 7. With MOLE_WHIFF_PENALTY_EN, press an unlit slot at score 0 -> score stays 0; at score 3 -> score becomes 2.
- reset asserted mid-PLAY with moles lit -> next edge: IDLE, all outputs at reset values; start within OVER -> new round begins with score=0.
